// File: rtl/booth_r4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_r4_seq_mult
//
// Iterative radix-4 Booth multiplier. The multiplier forms one Booth partial
// product per clock and adds it into a 2*WIDTH accumulator. An operand pair
// is taken through a valid/ready handshake. The product is returned through a
// second valid/ready handshake. Only one operation is in flight at a time.
//
// Parameters
//   WIDTH          operand width. It must be even and >= 4.
//                  The signed mode runs N = WIDTH/2 Booth steps.
//
// Ports
//   CLK            rising-edge clock
//   RST            synchronous, active-high reset
//   IN_VALID       operand pair valid
//   IN_READY       block can accept operands (high only while idle)
//   A_NUM          multiplicand, two's complement
//   B_NUM          multiplier, two's complement
//   MODE_UNSIGNED  (only with BOOTH_UNSIGNED_MODE_EN) treat operands as unsigned
//   OUT_VALID      PRODUCT valid (high only while a result is held)
//   OUT_READY      consumer accepts PRODUCT
//   PRODUCT        A_NUM * B_NUM, modulo 2^(2*WIDTH). It is exact for all
//                  operand pairs.
//   PP_DBG         partial product of the current step, sign-extended and
//                  unshifted. It is zero outside RUN.
//   PP_IDX         index of the Booth step being accumulated. It is zero
//                  outside RUN.
//
// Build option
//   BOOTH_UNSIGNED_MODE_EN   When defined, this adds MODE_UNSIGNED. The value
//                            is captured with the operands. The unsigned mode
//                            zero-extends both operands and runs N+1 steps.
//                            Its latency is therefore N+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  input  logic [WIDTH-1:0]                 A_NUM,
  input  logic [WIDTH-1:0]                 B_NUM,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic                             MODE_UNSIGNED,
`endif
  output logic                             OUT_VALID,
  input  logic                             OUT_READY,
  output logic [2*WIDTH-1:0]               PRODUCT,
  output logic [WIDTH+1:0]                 PP_DBG,
  output logic [$clog2(WIDTH/2+2)-1:0]     PP_IDX
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = $clog2(N + 2);
  // The stored multiplicand has one extra bit so that the unsigned mode can
  // zero-extend it without losing the MSB.
  localparam int AW    = WIDTH + 1;
  // The shifted multiplier holds {B extended to WIDTH+2 bits, 1'b0}. This
  // leaves room for the extra unsigned step.
  localparam int BW    = WIDTH + 3;
  // The partial product must hold +/-2A of an AW-bit operand.
  localparam int PW    = WIDTH + 3;
  localparam int PRW   = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_SIGNED   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_UNSIGNED = IDX_W'(N);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Radix-4 Booth recoding of one overlapping bit triplet into {0,+-A,+-2A}.
  function automatic logic signed [PW-1:0] booth_pp(
    input logic [2:0]            trip,
    input logic signed [AW-1:0]  a
  );
    logic signed [PW-1:0] a1;
    logic signed [PW-1:0] a2;
    a1 = {{(PW-AW){a[AW-1]}}, a};
    a2 = a1 <<< 1;
    case (trip)
      3'b001, 3'b010: booth_pp = a1;
      3'b011:         booth_pp = a2;
      3'b100:         booth_pp = -a2;
      3'b101, 3'b110: booth_pp = -a1;
      default:        booth_pp = '0;
    endcase
  endfunction

  // The partial product is sign-extended to the product width. It is then
  // weighted by 4^step and added. Any wrap-around is modulo 2^(2*WIDTH).
  function automatic logic signed [PRW-1:0] acc_add(
    input logic signed [PRW-1:0] acc,
    input logic signed [PW-1:0]  pp,
    input logic [IDX_W-1:0]      step
  );
    logic signed [PRW-1:0] ext;
    ext     = {{(PRW-PW){pp[PW-1]}}, pp};
    acc_add = acc + (ext << {step, 1'b0});
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]               state_q, state_d;
  logic signed [AW-1:0]     a_q,     a_d;
  logic signed [BW-1:0]     bx_q,    bx_d;
  logic signed [PRW-1:0]    acc_q,   acc_d;
  logic [PRW-1:0]           prod_q,  prod_d;
  logic [IDX_W-1:0]         step_q,  step_d;
  logic [IDX_W-1:0]         last_q,  last_d;

  logic                     mode_unsigned;
  logic signed [PW-1:0]     pp;

`ifdef BOOTH_UNSIGNED_MODE_EN
  assign mode_unsigned = MODE_UNSIGNED;
`else
  assign mode_unsigned = 1'b0;
`endif

  // The digit always comes from the low triplet of the shifted multiplier.
  assign pp = booth_pp(bx_q[2:0], a_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    step_d  = step_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          // The signed mode sign-extends both operands. The unsigned mode
          // zero-extends them. The signed mode only consumes the low WIDTH+1
          // bits of bx, so its extra sign bits never change the result.
          if (mode_unsigned) begin
            a_d    = {1'b0, A_NUM};
            bx_d   = {2'b00, B_NUM, 1'b0};
            last_d = LAST_UNSIGNED;
          end else begin
            a_d    = {A_NUM[WIDTH-1], A_NUM};
            bx_d   = {{2{B_NUM[WIDTH-1]}}, B_NUM, 1'b0};
            last_d = LAST_SIGNED;
          end
          acc_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d  = acc_add(acc_q, pp, step_q);
        bx_d   = bx_q >>> 2;
        step_d = step_q + 1'b1;
        if (step_q == last_q) begin
          prod_d  = acc_d;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // PRODUCT stays in prod_q after the handshake until the next result
        // overwrites it.
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      step_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      step_q  <= step_d;
      last_q  <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign PRODUCT   = prod_q;
  assign PP_DBG    = (state_q == S_RUN) ? pp[WIDTH+1:0] : '0;
  assign PP_IDX    = (state_q == S_RUN) ? step_q : '0;

endmodule
